// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
// Ports: clk, rst (async active-low); if_* fetch requester; dm_* data requester;
//        mem_* shared memory port (mem_req held for the whole access, mem_ack ends it).
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;
  state_t state, state_nx;
  logic [2:0] starve_cnt;
  logic dm_elig, if_elig, grant_if, grant_dm;
  // a requester whose ready pulse is this cycle is already served
  assign dm_elig = dm_req & ~dm_ready;
  assign if_elig = if_req & ~if_ready;
  // data wins unless fetch has been passed over STARVE_MAX times in a row
  assign grant_if = (state == IDLE) & if_elig & (~dm_elig | (starve_cnt == 3'(STARVE_MAX)));
  assign grant_dm = (state == IDLE) & dm_elig & ~grant_if;
  assign mem_req  = state != IDLE;
  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_req & ~dm_ready;
  always_comb begin
    state_nx = grant_if ? INSTR : grant_dm ? DATA : (mem_req & mem_ack) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
    end else begin
      state    <= state_nx;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (grant_if) begin
        starve_cnt <= '0;
        mem_addr   <= if_addr;
        mem_we     <= 1'b0;
      end
      if (grant_dm) begin
        mem_addr  <= dm_addr;
        mem_we    <= dm_we;
        mem_wdata <= dm_wdata;
        if (if_elig && starve_cnt < 3'(STARVE_MAX)) starve_cnt <= starve_cnt + 3'd1;
      end
      if (mem_req && mem_ack) begin
        if (state == INSTR) begin
          if_rdata <= mem_rdata;
          if_ready <= 1'b1;
        end else begin
          dm_ready <= 1'b1;
          if (!mem_we) dm_rdata <= mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;
  logic clk, rst;
  logic if_req, if_ready, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic dm_req, dm_we, dm_ready, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int compared = 0;
  int mismatched = 0;
  // model: is the port busy, who owns it, what was latched, what was returned
  logic m_busy, m_own_if, m_we, m_ifr, m_dmr;
  logic [31:0] m_addr, m_wdata, m_if_data, m_dm_data;
  int m_starve;
  logic prev_req;
  logic [31:0] grants[$];

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_busy = 0; m_own_if = 0; m_we = 0; m_ifr = 0; m_dmr = 0;
    m_addr = 0; m_wdata = 0; m_if_data = 0; m_dm_data = 0; m_starve = 0;
  endtask

  task automatic check_all();
    chkb("mem_req", mem_req, m_busy);
    chkb("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chkb("if_ready", if_ready, m_ifr);
    chkb("dm_ready", dm_ready, m_dmr);
    chk("if_rdata", if_rdata, m_if_data);
    chk("dm_rdata", dm_rdata, m_dm_data);
    chkb("if_stall", if_stall, if_req & ~m_ifr);
    chkb("dm_stall", dm_stall, dm_req & ~m_dmr);
  endtask

  // one clock: decide the model's next transaction state from the current inputs, then compare
  task automatic tick();
    logic nb, no, nw, nir, ndr, de, ie;
    logic [31:0] na, nd, nif, ndm;
    int ns;
    nb = m_busy; no = m_own_if; nw = m_we; na = m_addr; nd = m_wdata;
    nif = m_if_data; ndm = m_dm_data; ns = m_starve; nir = 0; ndr = 0;
    de = dm_req && !m_dmr;
    ie = if_req && !m_ifr;
    if (!m_busy) begin
      if (ie && (!de || m_starve == STARVE_MAX)) begin
        nb = 1; no = 1; na = if_addr; nw = 0; ns = 0;
      end else if (de) begin
        nb = 1; no = 0; na = dm_addr; nw = dm_we; nd = dm_wdata;
        if (ie && ns < STARVE_MAX) ns++;
      end
    end else if (mem_ack) begin
      nb = 0;
      if (m_own_if) begin nir = 1; nif = mem_rdata; end
      else begin ndr = 1; if (!m_we) ndm = mem_rdata; end
    end
    @(posedge clk);
    #1;
    m_busy = nb; m_own_if = no; m_we = nw; m_addr = na; m_wdata = nd;
    m_if_data = nif; m_dm_data = ndm; m_starve = ns; m_ifr = nir; m_dmr = ndr;
    check_all();
  endtask

  initial begin
    rst = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    reset_model();
    @(posedge clk);
    #1;
    chkb("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chkb("rst_if_ready", if_ready, 1'b0);
    chkb("rst_dm_ready", dm_ready, 1'b0);
    check_all();
    rst = 1;

    // single fetch, ack one cycle after mem_req
    if_req = 1; if_addr = 32'h40;
    tick();
    chkb("t1_req", mem_req, 1'b1);
    chk("t1_addr", mem_addr, 32'h40);
    chkb("t1_we", mem_we, 1'b0);
    mem_ack = 1; mem_rdata = 32'h2002000A;
    tick();
    chkb("t1_ready", if_ready, 1'b1);
    chk("t1_rdata", if_rdata, 32'h2002000A);
    chkb("t1_stall", if_stall, 1'b0);
    if_req = 0; mem_ack = 0;
    tick();

    // simultaneous fetch and load: data first, then fetch
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    tick();
    chk("t2_data_addr", mem_addr, 32'h100);
    chkb("t2_if_stall", if_stall, 1'b1);
    mem_ack = 1; mem_rdata = 32'h1234;
    tick();
    chkb("t2_dm_ready", dm_ready, 1'b1);
    chk("t2_dm_rdata", dm_rdata, 32'h1234);
    chkb("t2_if_stall2", if_stall, 1'b1);
    dm_req = 0; mem_ack = 0;
    tick();
    chkb("t2_if_grant", mem_req, 1'b1);
    chk("t2_if_addr", mem_addr, 32'h44);
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    tick();
    chkb("t2_if_ready", if_ready, 1'b1);
    if_req = 0; mem_ack = 0;
    tick();

    // store leaves load data untouched
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    tick();
    chkb("t4_we", mem_we, 1'b1);
    chk("t4_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t4_addr", mem_addr, 32'h200);
    mem_ack = 1; mem_rdata = 32'hFFFF0000;
    tick();
    chkb("t4_ready", dm_ready, 1'b1);
    chk("t4_rdata_kept", dm_rdata, 32'h1234);
    dm_req = 0; dm_we = 0; mem_ack = 0;
    tick();
    chkb("t4_ready_pulse", dm_ready, 1'b0);

    // slow memory while the fetch address wanders
    if_req = 1; if_addr = 32'h60;
    tick();
    if_addr = 32'h999;
    chk("t5_addr_c1", mem_addr, 32'h60);
    tick();
    chk("t5_addr_c2", mem_addr, 32'h60);
    tick();
    chk("t5_addr_c3", mem_addr, 32'h60);
    mem_ack = 1; mem_rdata = 32'hCAFE0001;
    tick();
    chkb("t5_ready", if_ready, 1'b1);
    chk("t5_rdata", if_rdata, 32'hCAFE0001);
    if_req = 0; mem_ack = 0;
    tick();
    chkb("t5_ready_once", if_ready, 1'b0);

    // asynchronous reset in the second cycle of a data access
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    tick();
    tick();
    #2 rst = 0;
    #1;
    reset_model();
    chkb("t6_req", mem_req, 1'b0);
    chk("t6_addr", mem_addr, 32'h0);
    chk("t6_if_rdata", if_rdata, 32'h0);
    chk("t6_dm_rdata", dm_rdata, 32'h0);
    check_all();
    @(posedge clk);
    #1 rst = 1;
    tick();
    chkb("t6_regrant", mem_req, 1'b1);
    chk("t6_regrant_addr", mem_addr, 32'h300);
    mem_ack = 1;
    tick();
    chkb("t6_ready", dm_ready, 1'b1);
    dm_req = 0; mem_ack = 0;
    tick();

    // data requester keeps the port busy; fetch forced through after STARVE_MAX grants
    prev_req = mem_req;
    for (int i = 0; i < 40; i++) begin
      dm_req = 1; dm_we = 0; dm_addr = 32'h300; if_addr = 32'h80;
      if_req = !m_dmr; mem_ack = 1; mem_rdata = $urandom;
      tick();
      if (mem_req && !prev_req) grants.push_back(mem_addr);
      prev_req = mem_req;
    end
    chk("starve_grants", grants.size() >= 6 ? 32'd1 : 32'd0, 32'd1);
    if (grants.size() >= 6) begin
      for (int i = 0; i < 6; i++)
        chk($sformatf("starve_grant%0d", i), grants[i], (i == 4) ? 32'h80 : 32'h300);
    end
    dm_req = 0; if_req = 0;
    repeat (3) tick();

    // randomized traffic with random memory latency
    for (int i = 0; i < 3000; i++) begin
      if (!if_req || m_ifr) begin
        if_req = $urandom_range(0, 1) == 1;
        if_addr = $urandom;
      end else if (m_dmr && $urandom_range(0, 3) == 0) begin
        if_req = 0;
      end
      if (!dm_req || m_dmr) begin
        dm_req = $urandom_range(0, 1) == 1;
        dm_we = $urandom_range(0, 1) == 1;
        dm_addr = $urandom;
        dm_wdata = $urandom;
      end
      mem_ack = $urandom_range(0, 2) == 0;
      mem_rdata = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
